data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Word-addressed data memory with a fixed, multi-cycle access latency. It sits directly downstream of the MEM stage and consumes that stage's chip-enable, write-enable, address and store-data outputs. It returns load data into the MEM stage's memory-data input, and raises a stall so the single-cycle core holds its state until the access completes. It also rejects misaligned and out-of-range accesses and reports them.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored (power of two, at least 4)
ADDR_BASE, 32'h0000_0000, byte address of word 0 (word aligned)
LATENCY, 2, BUSY cycles per access (1 to 15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
MemCE_i  input  1  access request; held stable by upstream while Stall_o=1
MemWE_i  input  1  1=store, 0=load; qualified by MemCE_i
MemAddr_i  input  32  byte address
MemData_i  input  32  store data
MemData_o  output  32  load data, valid in the DONE cycle of a good load
Stall_o  output  1  freeze request to the core
MemErr_o  output  1  one-cycle fault pulse in DONE
ErrAddr_o  output  32  address of the most recent faulting access

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, MemData_o=0, MemErr_o=0, ErrAddr_o=0, Stall_o=0.
  - Storage contents are not cleared; they initialise to zero at time 0 only.
  - Reset during BUSY aborts the access and no write occurs.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - Stall_o = MemCE_i (combinational).
  - On a rising edge with MemCE_i=1, capture addr, data and we, compute the fault flag, load counter=LATENCY-1, and go to BUSY.
  - With MemCE_i=0, stay in IDLE.
- BUSY:
  - Stall_o=1.
  - If counter!=0, decrement it and stay in BUSY.
  - If counter==0, perform the access on that edge and go to DONE:
    - Store without fault: write the captured data to mem[idx].
    - Load without fault: MemData_o <= mem[idx].
    - Any fault: no write, MemData_o <= 0, MemErr_o <= 1, ErrAddr_o <= captured addr.
- DONE:
  - Stall_o=0, so the core advances on this edge.
  - Next edge: MemErr_o <= 0 and state goes to IDLE unconditionally. A request present in DONE is never re-accepted.
- Latency: a request first seen in IDLE cycle T produces load data and MemErr_o in cycle T+1+LATENCY (DONE). Stall_o is high for cycles T..T+LATENCY, i.e. LATENCY+1 cycles.
- Addressing:
  - idx = (addr - ADDR_BASE) >> 2, 32-bit unsigned subtraction.
  - Fault if addr[1:0]!=0, or addr < ADDR_BASE, or addr >= ADDR_BASE + 4*DEPTH_WORDS.
  - The upper-bound comparison uses a 33-bit sum so a base near 2^32 does not wrap.
- MemData_o holds its last value except when updated in DONE; stores leave it unchanged.
- MemCE_i or other inputs changing during BUSY is an upstream violation. The captured request completes unaffected.
- MemWE_i with MemCE_i=0 is ignored.
- Back-to-back requests: IDLE to the next accept costs no extra cycle beyond DONE. Each access therefore occupies LATENCY+2 cycles.

Test Plan:
- Reset then store 0xDEADBEEF to 0x0000_0010 (LATENCY=2): Stall_o high exactly 3 cycles. Load from 0x10 then returns 0xDEADBEEF in its DONE cycle, MemErr_o=0.
- Load from unwritten 0x0000_0FFC (last word, DEPTH=1024): MemData_o=0, no fault. Load from 0x0000_1000: MemErr_o pulses 1 cycle, ErrAddr_o=0x1000, MemData_o=0.
- Store to 0x0000_0006 (misaligned): MemErr_o pulse, ErrAddr_o=6. A following load of 0x4 returns its prior value, proving no partial write.
- Assert rst=0 mid-BUSY of a store of 0x12345678 to 0x20: Stall_o drops immediately, state IDLE. A later load of 0x20 returns the old value 0.
- Two consecutive load requests (CE held across DONE): second accept occurs in the cycle after DONE. Total 8 cycles for LATENCY=2, no duplicate access.
- LATENCY=1 build: store 0xA5A5A5A5 to 0x8, then load: Stall_o high 2 cycles per access, data 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with a fixed multi-cycle access latency.
// Freezes the core with Stall_o while an access is in flight and reports
// misaligned or out-of-range accesses through MemErr_o / ErrAddr_o.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemCE_i,
  input  logic        MemWE_i,
  input  logic [31:0] MemAddr_i,
  input  logic [31:0] MemData_i,
  output logic [31:0] MemData_o,
  output logic        Stall_o,
  output logic        MemErr_o,
  output logic [31:0] ErrAddr_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  // One past the last valid byte address, kept in 33 bits so a base near
  // the top of the address space does not wrap.
  localparam logic [32:0] ADDR_END = 33'(ADDR_BASE) + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               fault_q, fault_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic               mem_err_q, mem_err_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic               mem_we_c;
  logic [IDX_W-1:0]   mem_idx_c;
  logic               below_c;
  logic               above_c;
  logic               misalign_c;
  logic               fault_c;
  logic               stall_c;

  // Fault classification of the incoming request address.
  always_comb begin
    misalign_c = (MemAddr_i[1:0] != 2'b00);
    below_c    = 1'((33'(MemAddr_i) - 33'(ADDR_BASE)) >> 32);
    above_c    = (33'(MemAddr_i) >= ADDR_END);
    fault_c    = misalign_c | below_c | above_c;
  end

  // Word index of the captured address relative to the base.
  always_comb begin
    mem_idx_c = IDX_W'((addr_q - ADDR_BASE) >> 2);
  end

  // Next-state, capture and access logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    fault_d    = fault_q;
    mem_data_d = mem_data_q;
    mem_err_d  = mem_err_q;
    err_addr_d = err_addr_q;
    mem_we_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MemCE_i) begin
          addr_d  = MemAddr_i;
          wdata_d = MemData_i;
          we_d    = MemWE_i;
          fault_d = fault_c;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          if (fault_q) begin
            mem_data_d = '0;
            mem_err_d  = 1'b1;
            err_addr_d = addr_q;
          end else if (we_q) begin
            mem_we_c = 1'b1;
          end else begin
            mem_data_d = mem_q[mem_idx_c];
          end
        end
      end
      ST_DONE: begin
        // Any request still presented here belongs to the next core cycle.
        mem_err_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      fault_q    <= 1'b0;
      mem_data_q <= '0;
      mem_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      fault_q    <= fault_d;
      mem_data_q <= mem_data_d;
      mem_err_q  <= mem_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_idx_c] <= wdata_q;
    end
  end

  // Stall follows the request in IDLE so the core freezes in the accept cycle.
  always_comb begin
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: stall_c = MemCE_i;
      ST_BUSY: stall_c = 1'b1;
      ST_DONE: stall_c = 1'b0;
      default: stall_c = 1'b0;
    endcase
  end

  assign Stall_o   = rst & stall_c;
  assign MemData_o = mem_data_q;
  assign MemErr_o  = mem_err_q;
  assign ErrAddr_o = err_addr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one LATENCY=2 and one LATENCY=1 instance.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;

  logic        ce0, we0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0, eaddr0;
  logic        stall0, err0;

  logic        ce1, we1;
  logic [31:0] addr1, wdata1;
  logic [31:0] rdata1, eaddr1;
  logic        stall1, err1;

  int checks;
  int errors;

  data_mem_ctrl #(
    .DEPTH_WORDS(1024),
    .ADDR_BASE  (32'h0000_0000),
    .LATENCY    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemCE_i  (ce0),
    .MemWE_i  (we0),
    .MemAddr_i(addr0),
    .MemData_i(wdata0),
    .MemData_o(rdata0),
    .Stall_o  (stall0),
    .MemErr_o (err0),
    .ErrAddr_o(eaddr0)
  );

  data_mem_ctrl #(
    .DEPTH_WORDS(1024),
    .ADDR_BASE  (32'h0000_0000),
    .LATENCY    (1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .MemCE_i  (ce1),
    .MemWE_i  (we1),
    .MemAddr_i(addr1),
    .MemData_i(wdata1),
    .MemData_o(rdata1),
    .Stall_o  (stall1),
    .MemErr_o (err1),
    .ErrAddr_o(eaddr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One complete access; returns stall cycle count and the DONE-cycle outputs.
  task automatic mem_access(input bit sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, output int n_stall,
                            output logic [31:0] rd, output logic er,
                            output logic [31:0] ea);
    @(negedge clk);
    if (sel) begin ce1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
    else     begin ce0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
    n_stall = 0;
    #1;
    while ((sel ? stall1 : stall0) && n_stall < 40) begin
      n_stall++;
      @(negedge clk);
      #1;
    end
    rd = sel ? rdata1 : rdata0;
    er = sel ? err1 : err0;
    ea = sel ? eaddr1 : eaddr0;
    if (sel) begin ce1 = 1'b0; we1 = 1'b0; end
    else     begin ce0 = 1'b0; we0 = 1'b0; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    logic [31:0] rd, ea;
    logic        er;
    logic [7:0]  svec;
    logic [31:0] d_first, d_second;

    checks = 0;
    errors = 0;
    ce0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    ce1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    rst = 1'b0;

    // Reset state
    #3;
    check_eq("rst_stall", 32'(stall0), 32'd0);
    check_eq("rst_data",  rdata0, 32'd0);
    check_eq("rst_err",   32'(err0), 32'd0);
    check_eq("rst_eaddr", eaddr0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Store then load back
    mem_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, n, rd, er, ea);
    check_eq("st10_stall", 32'(n), 32'd3);
    check_eq("st10_err",   32'(er), 32'd0);
    check_eq("st10_data_unchanged", rd, 32'd0);
    mem_access(1'b0, 1'b0, 32'h10, 32'h0, n, rd, er, ea);
    check_eq("ld10_stall", 32'(n), 32'd3);
    check_eq("ld10_data",  rd, 32'hDEAD_BEEF);
    check_eq("ld10_err",   32'(er), 32'd0);

    // Last valid word and first out-of-range word
    mem_access(1'b0, 1'b0, 32'hFFC, 32'h0, n, rd, er, ea);
    check_eq("ldffc_data", rd, 32'd0);
    check_eq("ldffc_err",  32'(er), 32'd0);
    mem_access(1'b0, 1'b0, 32'h1000, 32'h0, n, rd, er, ea);
    check_eq("ld1000_err",   32'(er), 32'd1);
    check_eq("ld1000_eaddr", ea, 32'h1000);
    check_eq("ld1000_data",  rd, 32'd0);
    check_eq("ld1000_pulse", 32'(err0), 32'd0);
    check_eq("ld1000_eaddr_hold", eaddr0, 32'h1000);

    // Misaligned store must not disturb the neighbouring word
    mem_access(1'b0, 1'b1, 32'h4, 32'h1111_2222, n, rd, er, ea);
    check_eq("st4_err", 32'(er), 32'd0);
    mem_access(1'b0, 1'b1, 32'h6, 32'hFFFF_FFFF, n, rd, er, ea);
    check_eq("st6_err",   32'(er), 32'd1);
    check_eq("st6_eaddr", ea, 32'h6);
    mem_access(1'b0, 1'b0, 32'h4, 32'h0, n, rd, er, ea);
    check_eq("ld4_data", rd, 32'h1111_2222);
    check_eq("ld4_err",  32'(er), 32'd0);

    // Write enable without chip enable is ignored
    @(negedge clk);
    we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h0BAD_0BAD;
    #1;
    check_eq("we_only_stall", 32'(stall0), 32'd0);
    @(negedge clk);
    we0 = 1'b0;
    mem_access(1'b0, 1'b0, 32'h4, 32'h0, n, rd, er, ea);
    check_eq("we_only_nowrite", rd, 32'h1111_2222);

    // Reset mid-BUSY aborts the store
    @(negedge clk);
    ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    @(negedge clk);
    check_eq("abort_busy_stall", 32'(stall0), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("abort_stall_drop", 32'(stall0), 32'd0);
    check_eq("abort_data_rst",   rdata0, 32'd0);
    ce0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_idle", 32'(stall0), 32'd0);
    mem_access(1'b0, 1'b0, 32'h20, 32'h0, n, rd, er, ea);
    check_eq("abort_nowrite", rd, 32'd0);

    // Back-to-back loads with the request held through DONE
    d_first  = '0;
    d_second = '0;
    @(negedge clk);
    ce0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    for (int i = 0; i < 8; i++) begin
      #1;
      svec[i] = stall0;
      if (i == 3) d_first  = rdata0;
      if (i == 7) begin
        d_second = rdata0;
        ce0 = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    check_eq("b2b_stall_pattern", 32'(svec), 32'h77);
    check_eq("b2b_data_first",    d_first,   32'hDEAD_BEEF);
    check_eq("b2b_data_second",   d_second,  32'hDEAD_BEEF);
    check_eq("b2b_no_extra",      32'(stall0), 32'd0);

    // LATENCY=1 instance
    mem_access(1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5, n, rd, er, ea);
    check_eq("l1_st_stall", 32'(n), 32'd2);
    check_eq("l1_st_err",   32'(er), 32'd0);
    mem_access(1'b1, 1'b0, 32'h8, 32'h0, n, rd, er, ea);
    check_eq("l1_ld_stall", 32'(n), 32'd2);
    check_eq("l1_ld_data",  rd, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
